// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: packs 8 samples into a frame, starts the FFT core, then drains 8 magnitudes.
// Optional peak tracker enabled by FFT_FRAME_PEAK_EN.
module fft_frame_ctrl #(
  parameter int DATA_W  = 8,
  parameter int N_PTS   = 8,
  parameter int FFT_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [N_PTS*DATA_W-1:0] fft_x,
  output logic                    fft_start,
  output logic [2:0]              bin_sel,
  input  logic [DATA_W-1:0]       mag_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [2:0]              out_bin,
  output logic                    busy,
  output logic                    frame_done,
  output logic [2:0]              peak_bin,
  output logic [DATA_W-1:0]       peak_mag
);
  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;
  state_t     state;
  logic [2:0] idx;
  logic [7:0] cnt;
  assign in_ready  = state == LOAD;
  assign out_valid = state == DRAIN;
  assign busy      = state != LOAD;
  assign out_data  = mag_data;
  assign out_bin   = bin_sel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      idx        <= '0;
      cnt        <= '0;
      fft_x      <= '0;
      bin_sel    <= '0;
      fft_start  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fft_start  <= 1'b0;
      frame_done <= 1'b0;
      if (clear) begin
        state   <= LOAD;
        idx     <= '0;
        bin_sel <= '0;
      end else begin
        case (state)
          LOAD: if (in_valid) begin
            fft_x[idx*DATA_W +: DATA_W] <= in_data;
            idx <= idx + 3'd1;
            if (idx == 3'(N_PTS-1)) begin
              state     <= RUN;
              fft_start <= 1'b1;
              cnt       <= 8'(FFT_LAT);
            end
          end
          // the start cycle is the first of FFT_LAT wait cycles
          RUN: if (cnt == 8'd1) begin
            state   <= DRAIN;
            bin_sel <= '0;
          end else cnt <= cnt - 8'd1;
          DRAIN: if (out_ready) begin
            bin_sel <= bin_sel + 3'd1;
            if (bin_sel == 3'(N_PTS-1)) begin
              state      <= LOAD;
              idx        <= '0;
              frame_done <= 1'b1;
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end
`ifdef FFT_FRAME_PEAK_EN
  logic [DATA_W-1:0] trk_mag;
  logic [2:0]        trk_bin;
  logic              take;
  assign take = bin_sel == 3'd0 || out_data > trk_mag;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_mag  <= '0;
      trk_bin  <= '0;
      peak_mag <= '0;
      peak_bin <= '0;
    end else if (!clear && out_valid && out_ready) begin
      if (take) begin
        trk_mag <= out_data;
        trk_bin <= bin_sel;
      end
      if (bin_sel == 3'(N_PTS-1)) begin
        peak_mag <= take ? out_data : trk_mag;
        peak_bin <= take ? bin_sel : trk_bin;
      end
    end
  end
`else
  assign peak_bin = '0;
  assign peak_mag = '0;
`endif
endmodule
